phy_mem_arbiter: RTL and testbench

Shares the single physical memory controller port (is_write/addr/data_in/data_out/busy) among NREQ requesters, e.g. instruction fetch, data access and a DMA/VGA filler. It sits between the CPU-side masters and the memory controller. It arbitrates round-robin, sequences each access as either a timed read or a write pulse followed by a wait for the controller's busy to drop, and returns data and a one-cycle ack to the winner. A sticky error flag records writes whose busy never clears.

---
 rtl/phy_mem_arbiter_pkg.sv | 24 ++
 rtl/phy_mem_arbiter_if.sv | 21 ++
 rtl/phy_mem_arbiter_rr_pick.sv | 32 +++
 rtl/phy_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_phy_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_mem_arbiter_pkg.sv
// phy_mem_arb_pkg: shared definitions for the physical memory port arbiter.
//   arb_state_e    - FSM state encoding
//   DEF_RD_WAIT    - default read capture delay (cycles)
//   DEF_WR_TIMEOUT - default write busy timeout (cycles)
//   CNT_W          - width of the shared wait counter
//   id_width()     - width of a requester index for n requesters
package phy_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_PULSE = 2'd2,
    ST_WR_WAIT  = 2'd3
  } arb_state_e;

  localparam int DEF_RD_WAIT    = 2;
  localparam int DEF_WR_TIMEOUT = 15;
  localparam int CNT_W          = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_mem_arbiter_if.sv
// phy_mem_arbiter_if: requester-side bus of the memory arbiter.
//   req   - per-requester request, held with payload until ack
//   we    - per-requester write flag
//   addr  - per-requester byte address, slice i = [32i+31:32i]
//   wdata - per-requester write data, same slicing
//   ack   - one-cycle completion pulse, one-hot or zero
//   rdata - read data, valid while ack is high
// master: the requesters; slave: the arbiter.
interface phy_mem_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [32*NREQ-1:0]   addr;
  logic [32*NREQ-1:0]   wdata;
  logic [NREQ-1:0]      ack;
  logic [31:0]          rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/phy_mem_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   eligible - requesters that may be granted
//   last     - index granted most recently; search starts at last+1 and wraps
//   found    - at least one requester is eligible
//   winner   - first eligible index in rotated order (last when none found)
module rr_pick
  import phy_mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  last,
  output logic            found,
  output logic [IDW-1:0]  winner
);

  // Offset k = 1 is the highest priority, so last itself is considered last.
  always_comb begin
    found  = 1'b0;
    winner = last;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && eligible[i] && ((int'(last) + k) % NREQ) == i) begin
          found  = 1'b1;
          winner = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/phy_mem_arbiter.sv
// phy_mem_arbiter: shares one memory controller port among NREQ requesters.
// Round-robin grant, then either a timed read or a one-cycle write pulse
// followed by a wait for the controller's busy to drop.
//   clk, rst         - clock (rising edge), synchronous active-high reset
//   bus              - requester bus (req/we/addr/wdata in, ack/rdata out)
//   grant_id         - current or last granted requester
//   arb_busy         - high whenever an access is in progress
//   timeout_err      - sticky, set when a write's busy never cleared
//   mem_is_write     - controller write strobe (one-cycle pulse)
//   mem_addr         - controller address
//   mem_data_in      - controller write data
//   mem_data_out     - controller read data (combinational)
//   mem_busy         - controller busy
//
// state       | meaning
// ST_IDLE     | no access; pick next requester
// ST_RD_WAIT  | address held, counting to read capture
// ST_WR_PULSE | mem_is_write high for this one cycle
// ST_WR_WAIT  | waiting for mem_busy low or timeout
module phy_mem_arbiter
  import phy_mem_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int RD_WAIT    = DEF_RD_WAIT,
  parameter int WR_TIMEOUT = DEF_WR_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  phy_mem_arbiter_if.slave        bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    arb_busy,
  output logic                    timeout_err,
  output logic                    mem_is_write,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_data_in,
  input  logic [31:0]             mem_data_out,
  input  logic                    mem_busy
);

  localparam int IDW = id_width(NREQ);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [NREQ-1:0]  ack_q, ack_nxt;
  logic [31:0]      rdata_q, rdata_nxt;
  logic [IDW-1:0]   grant_nxt;
  logic             err_nxt;
  logic             is_wr_nxt;
  logic [31:0]      addr_nxt, din_nxt;

  logic [NREQ-1:0]  eligible;
  logic             pick_found;
  logic [IDW-1:0]   pick_id;
  logic             win_we;
  logic [31:0]      win_addr, win_data;

  // A requester acked this cycle may still show req high; mask it so it
  // is not regranted on its own stale request.
  assign eligible = bus.req & ~ack_q;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .eligible (eligible),
    .last     (grant_id),
    .found    (pick_found),
    .winner   (pick_id)
  );

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == pick_id) begin
        win_we   = bus.we[i];
        win_addr = bus.addr[32*i +: 32];
        win_data = bus.wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = '0;
    rdata_nxt = rdata_q;
    grant_nxt = grant_id;
    err_nxt   = timeout_err;
    is_wr_nxt = mem_is_write;
    addr_nxt  = mem_addr;
    din_nxt   = mem_data_in;

    case (state)
      ST_IDLE: begin
        is_wr_nxt = 1'b0;
        if (pick_found) begin
          grant_nxt = pick_id;
          addr_nxt  = win_addr;
          din_nxt   = win_data;
          cnt_nxt   = '0;
          if (win_we) begin
            is_wr_nxt = 1'b1;
            state_nxt = ST_WR_PULSE;
          end else begin
            state_nxt = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        if (cnt == CNT_W'(RD_WAIT - 1)) begin
          rdata_nxt          = mem_data_out;
          ack_nxt[grant_id]  = 1'b1;
          state_nxt          = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_WR_PULSE: begin
        is_wr_nxt = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (!mem_busy) begin
          ack_nxt[grant_id] = 1'b1;
          state_nxt         = ST_IDLE;
        end else if (cnt == CNT_W'(WR_TIMEOUT - 1)) begin
          err_nxt           = 1'b1;
          ack_nxt[grant_id] = 1'b1;
          state_nxt         = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      grant_id     <= IDW'(NREQ - 1);
      arb_busy     <= 1'b0;
      timeout_err  <= 1'b0;
      mem_is_write <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ack_q        <= ack_nxt;
      rdata_q      <= rdata_nxt;
      grant_id     <= grant_nxt;
      arb_busy     <= (state_nxt != ST_IDLE);
      timeout_err  <= err_nxt;
      mem_is_write <= is_wr_nxt;
      mem_addr     <= addr_nxt;
      mem_data_in  <= din_nxt;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_phy_mem_arbiter.sv
// tb_phy_mem_arbiter: randomized bench for phy_mem_arbiter with a
// transaction-level reference model (grant time, completion edge, data).
module tb_phy_mem_arbiter;
  localparam int NREQ       = 3;
  localparam int RD_WAIT    = 2;
  localparam int WR_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  grant_id;
  logic        arb_busy, timeout_err, mem_is_write;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_busy = 1'b0;

  phy_mem_arbiter_if #(.NREQ(NREQ)) bus ();

  phy_mem_arbiter #(
    .NREQ       (NREQ),
    .RD_WAIT    (RD_WAIT),
    .WR_TIMEOUT (WR_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .timeout_err  (timeout_err),
    .mem_is_write (mem_is_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_busy     (mem_busy)
  );

  always #5 clk = ~clk;

  // Controller memory (what the DUT really wrote) and reference memory.
  logic [31:0] ctrl_mem [8];
  logic [31:0] ref_mem  [8];
  assign mem_data_out = ctrl_mem[mem_addr[4:2]];

  int n_chk = 0;
  int n_bad = 0;
  int edge_n = 0;

  // reference model: one access in flight, described by grant and done edges
  bit              m_act, m_we, m_to;
  int              m_id, m_start, m_done, m_bl, last_id;
  logic [31:0]     m_addr;
  logic [NREQ-1:0] exp_ack;
  logic [31:0]     exp_rdata, exp_addr, exp_din;
  int              exp_grant;
  bit              exp_err, exp_wr, exp_busy;
  int              force_bl = -1;
  bit              rand_mode = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  function automatic int rand_bl();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 11) return r;
    if (r < 13) return WR_TIMEOUT - 1;
    return WR_TIMEOUT + (r - 13);
  endfunction

  task automatic model_reset();
    m_act = 0; m_we = 0; m_to = 0;
    exp_ack = '0; exp_rdata = '0; exp_addr = '0; exp_din = '0;
    exp_grant = NREQ - 1; last_id = NREQ - 1;
    exp_err = 0; exp_wr = 0; exp_busy = 0;
  endtask

  task automatic model_edge(input int e);
    logic [NREQ-1:0] elig;
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_act) begin
      elig = bus.req & ~exp_ack;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        for (int i = 0; i < NREQ; i++)
          if (w < 0 && elig[i] && i == (last_id + k) % NREQ) w = i;
      if (w >= 0) begin
        m_act = 1; m_id = w; m_start = e; last_id = w; exp_grant = w;
        m_we = bus.we[w];
        m_addr = bus.addr[32*w +: 32];
        exp_addr = m_addr;
        exp_din = bus.wdata[32*w +: 32];
        if (m_we) begin
          m_bl = (force_bl >= 0) ? force_bl : rand_bl();
          m_done = e + 2 + ((m_bl < WR_TIMEOUT - 1) ? m_bl : WR_TIMEOUT - 1);
          m_to = (m_bl >= WR_TIMEOUT);
          ref_mem[m_addr[4:2]] = exp_din;
        end else begin
          m_done = e + RD_WAIT;
          m_to = 0;
        end
      end
    end
    exp_ack = '0;
    if (m_act && e == m_done) begin
      exp_ack[m_id] = 1'b1;
      if (!m_we) exp_rdata = ref_mem[m_addr[4:2]];
      if (m_to) exp_err = 1;
      m_act = 0;
    end
    exp_wr = m_act && m_we && (e == m_start);
    exp_busy = m_act;
  endtask

  task automatic new_payload(input int i);
    logic [31:0] a;
    bus.we[i] = ($urandom_range(0, 9) < 4);
    a = $urandom();
    a[1:0] = 2'b00;
    bus.addr[32*i +: 32] = a;
    bus.wdata[32*i +: 32] = $urandom();
  endtask

  task automatic drive_random();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ack[i]) begin
        if ($urandom_range(0, 1) == 1) new_payload(i);
        else bus.req[i] = 1'b0;
      end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
        bus.req[i] = 1'b1;
        new_payload(i);
      end
    end
  endtask

  task automatic check_outputs();
    chk_val("ack", 32'(bus.ack), 32'(exp_ack));
    chk_val("rdata", bus.rdata, exp_rdata);
    chk_val("grant_id", 32'(grant_id), 32'(exp_grant));
    chk_val("arb_busy", 32'(arb_busy), 32'(exp_busy));
    chk_val("timeout_err", 32'(timeout_err), 32'(exp_err));
    chk_val("mem_is_write", 32'(mem_is_write), 32'(exp_wr));
    chk_val("mem_addr", mem_addr, exp_addr);
    chk_val("mem_data_in", mem_data_in, exp_din);
  endtask

  // One clock: controller store and busy drive at negedge, model evaluates
  // the coming edge, DUT outputs checked 1 time unit after it.
  task automatic step();
    @(negedge clk);
    if (mem_is_write === 1'b1) ctrl_mem[mem_addr[4:2]] = mem_data_in;
    edge_n++;
    if (m_act && m_we && edge_n >= m_start + 2 && edge_n <= m_done)
      mem_busy = (edge_n < m_start + 2 + m_bl);
    else
      mem_busy = $urandom_range(0, 1) == 1;
    model_edge(edge_n);
    @(posedge clk);
    #1;
    check_outputs();
    if (rand_mode) drive_random();
  endtask

  task automatic wait_idle();
    int n;
    bus.req = '0;
    n = 0;
    while (n < 50 && (m_act || exp_ack != '0)) begin
      step();
      n++;
    end
  endtask

  // Single access from an idle arbiter; latency counted in clocks from the
  // edge that first sees req to the cycle ack is observed.
  task automatic run_one(input int id, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int bl, input int lat,
                         input string tag);
    int n;
    bit got;
    wait_idle();
    bus.we[id] = w;
    bus.addr[32*id +: 32] = a;
    bus.wdata[32*id +: 32] = d;
    bus.req[id] = 1'b1;
    force_bl = bl;
    n = 0;
    got = 0;
    while (n < 40 && !got) begin
      step();
      n++;
      if (bus.ack[id] === 1'b1) got = 1;
    end
    chk_val(tag, 32'(n), 32'(lat));
    bus.req[id] = 1'b0;
    force_bl = -1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ctrl_mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i]  = 32'h1000_0000 + 32'(i);
    end
    ctrl_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4]  = 32'hDEAD_BEEF;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    model_reset();

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    run_one(1, 1'b0, 32'h0000_0010, 32'h0, -1, RD_WAIT + 1, "lat_read");
    chk_val("read_data", bus.rdata, 32'hDEAD_BEEF);
    run_one(2, 1'b1, 32'h1FD0_0400, 32'h1234_5678, 4, 3 + 4, "lat_write_busy4");
    chk_val("err_after_write", 32'(timeout_err), 32'h0);
    run_one(0, 1'b1, 32'h0000_0008, 32'hCAFE_0001, 0, 3, "lat_write_nobusy");
    run_one(0, 1'b1, 32'h0000_000C, 32'hCAFE_0002, 1, 4, "lat_write_busy1");
    run_one(1, 1'b0, 32'h1FD0_0400, 32'h0, -1, RD_WAIT + 1, "lat_readback");
    chk_val("readback_data", bus.rdata, 32'h1234_5678);

    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;

    run_one(2, 1'b1, 32'h0000_0014, 32'h5555_AAAA, 20, WR_TIMEOUT + 2, "lat_timeout");
    repeat (5) step();
    chk_val("err_sticky", 32'(timeout_err), 32'h1);

    wait_idle();
    bus.we[1] = 1'b0;
    bus.addr[32*1 +: 32] = 32'h0000_0024;
    bus.req[1] = 1'b1;
    step();
    chk_val("busy_in_read", 32'(arb_busy), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req[1] = 1'b0;
    chk_val("rst_ack", 32'(bus.ack), 32'h0);
    chk_val("rst_is_write", 32'(mem_is_write), 32'h0);
    chk_val("rst_grant", 32'(grant_id), 32'(NREQ - 1));
    chk_val("rst_err", 32'(timeout_err), 32'h0);
    bus.we[0] = 1'b0; bus.we[2] = 1'b0;
    bus.addr[32*0 +: 32] = 32'h0000_0004;
    bus.addr[32*2 +: 32] = 32'h0000_0018;
    bus.req[0] = 1'b1; bus.req[2] = 1'b1;
    step();
    chk_val("first_after_rst", 32'(grant_id), 32'h0);
    repeat (10) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (exp_ack[i]) bus.req[i] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
